vslide_issue: RTL and testbench

// Command-driven beat sequencer feeding the vector slide pipeline. Accepts one

---
 rtl/vslide_issue_if.sv | 49 ++++
 rtl/vslide_issue.sv | 132 +++++++++++++
 tb/tb_vslide_issue.sv | 237 +++++++++++++++++++++++
 3 files changed

// File: rtl/vslide_issue_if.sv
// vslide_issue_if: command, VRF read and slide-unit output bundle of vslide_issue.
//   cmd_*     : slide command offered by decode (cmd_valid/cmd_ready handshake)
//   vrf_rd_*  : VRF beat read port, data returns one cycle after vrf_rd_en
//   out_*     : beat stream to the slide unit, all fields zero when out_valid=0
//   busy      : sequencer is processing a command
//   master    : sequencer side, slave : decode/VRF/slide-unit side
interface vslide_issue_if #(
   parameter int DATA_WIDTH = 64,
   parameter int ADDR_WIDTH = 32,
   parameter int SEW_WIDTH  = 2,
   parameter int VL_WIDTH   = 16,
   parameter int BE_WIDTH   = DATA_WIDTH / 8
);
   logic                  cmd_valid;
   logic                  cmd_ready;
   logic                  cmd_opSel;
   logic                  cmd_insert;
   logic [SEW_WIDTH-1:0]  cmd_sew;
   logic [VL_WIDTH-1:0]   cmd_vl;
   logic [ADDR_WIDTH-1:0] cmd_src_addr;
   logic [ADDR_WIDTH-1:0] cmd_dst_addr;
   logic [DATA_WIDTH-1:0] cmd_scalar;
   logic                  vrf_rd_en;
   logic [ADDR_WIDTH-1:0] vrf_rd_addr;
   logic [DATA_WIDTH-1:0] vrf_rd_data;
   logic                  out_valid;
   logic [DATA_WIDTH-1:0] out_vec0;
   logic [DATA_WIDTH-1:0] out_vec1;
   logic [SEW_WIDTH-1:0]  out_sew;
   logic                  out_opSel;
   logic                  out_insert;
   logic                  out_start;
   logic                  out_end;
   logic [ADDR_WIDTH-1:0] out_addr;
   logic [BE_WIDTH-1:0]   out_be;
   logic                  busy;
   modport master (
      input  cmd_valid, cmd_opSel, cmd_insert, cmd_sew, cmd_vl, cmd_src_addr, cmd_dst_addr,
             cmd_scalar, vrf_rd_data,
      output cmd_ready, vrf_rd_en, vrf_rd_addr, out_valid, out_vec0, out_vec1, out_sew,
             out_opSel, out_insert, out_start, out_end, out_addr, out_be, busy
   );
   modport slave (
      output cmd_valid, cmd_opSel, cmd_insert, cmd_sew, cmd_vl, cmd_src_addr, cmd_dst_addr,
             cmd_scalar, vrf_rd_data,
      input  cmd_ready, vrf_rd_en, vrf_rd_addr, out_valid, out_vec0, out_vec1, out_sew,
             out_opSel, out_insert, out_start, out_end, out_addr, out_be, busy
   );
endinterface

// File: rtl/vslide_issue.sv
// vslide_issue: slide command beat sequencer, reads the source group from the VRF
// and streams one beat per cycle to the slide unit.
//   i_clk   : clock
//   i_rst_n : synchronous active-low reset
//   io_bus  : vslide_issue_if.master (command in, VRF read port, beat stream out)
module vslide_issue #(
   parameter int DATA_WIDTH = 64,
   parameter int ADDR_WIDTH = 32,
   parameter int SEW_WIDTH  = 2,
   parameter int VL_WIDTH   = 16,
   parameter int BE_WIDTH   = DATA_WIDTH / 8
) (
   input logic             i_clk,
   input logic             i_rst_n,
   vslide_issue_if.master  io_bus
);
   localparam int BW = $clog2(BE_WIDTH);
   localparam int CW = VL_WIDTH + 3;
   typedef enum logic [1:0] {IDLE, READ, DRAIN} state_t;
   state_t                r_state;
   logic                  r_ready;
   logic                  r_busy;
   logic                  r_rd_en;
   logic                  r_opsel;
   logic                  r_insert;
   logic                  r_out_valid;
   logic                  r_out_start;
   logic                  r_out_end;
   logic [SEW_WIDTH-1:0]  r_sew;
   logic [DATA_WIDTH-1:0] r_scalar;
   logic [ADDR_WIDTH-1:0] r_rd_addr;
   logic [ADDR_WIDTH-1:0] r_dst_addr;
   logic [ADDR_WIDTH-1:0] r_out_addr;
   logic [CW-1:0]         r_cnt;
   logic [CW-1:0]         r_last;
   logic [BW-1:0]         r_rem;
   logic [BE_WIDTH-1:0]   r_out_be;
   logic [CW-1:0]         w_bytes;
   logic [CW-1:0]         w_nbeats;
   logic [BE_WIDTH-1:0]   w_be;
   logic                  w_accept;
   always_comb begin
      w_bytes  = CW'(io_bus.cmd_vl) << io_bus.cmd_sew;
      w_nbeats = (w_bytes >> BW) + CW'(|w_bytes[BW-1:0]);
      // only the final beat can be partial; a zero remainder means it is full
      w_be     = (r_cnt != r_last || r_rem == '0) ? '1 : ~({BE_WIDTH{1'b1}} << r_rem);
      w_accept = r_ready && io_bus.cmd_valid;
   end
   // the output stage captures the metadata of the read issued this cycle so it
   // lines up with the VRF data returning one cycle later
   always_ff @(posedge i_clk) begin
      if (!i_rst_n) begin
         r_state     <= IDLE;
         r_ready     <= 1'b1;
         r_busy      <= 1'b0;
         r_rd_en     <= 1'b0;
         r_opsel     <= 1'b0;
         r_insert    <= 1'b0;
         r_sew       <= '0;
         r_scalar    <= '0;
         r_rd_addr   <= '0;
         r_dst_addr  <= '0;
         r_cnt       <= '0;
         r_last      <= '0;
         r_rem       <= '0;
         r_out_valid <= 1'b0;
         r_out_start <= 1'b0;
         r_out_end   <= 1'b0;
         r_out_addr  <= '0;
         r_out_be    <= '0;
      end else begin
         r_out_valid <= 1'b0;
         r_out_start <= 1'b0;
         r_out_end   <= 1'b0;
         r_out_addr  <= '0;
         r_out_be    <= '0;
         case (r_state)
            IDLE: if (w_accept) begin
               r_opsel    <= io_bus.cmd_opSel;
               r_insert   <= io_bus.cmd_insert;
               r_sew      <= io_bus.cmd_sew;
               r_scalar   <= io_bus.cmd_scalar;
               r_rd_addr  <= io_bus.cmd_src_addr;
               r_dst_addr <= io_bus.cmd_dst_addr;
               r_cnt      <= '0;
               r_last     <= w_nbeats - CW'(1);
               r_rem      <= w_bytes[BW-1:0];
               if (w_nbeats != '0) begin
                  r_state <= READ;
                  r_ready <= 1'b0;
                  r_busy  <= 1'b1;
                  r_rd_en <= 1'b1;
               end
            end
            READ: begin
               r_out_valid <= 1'b1;
               r_out_start <= r_cnt == '0;
               r_out_end   <= r_cnt == r_last;
               r_out_addr  <= r_dst_addr;
               r_out_be    <= w_be;
               r_dst_addr  <= r_dst_addr + ADDR_WIDTH'(1);
               r_rd_addr   <= r_rd_addr + ADDR_WIDTH'(1);
               r_cnt       <= r_cnt + CW'(1);
               if (r_cnt == r_last) begin
                  r_rd_en <= 1'b0;
                  r_state <= DRAIN;
               end
            end
            DRAIN: begin
               r_state <= IDLE;
               r_ready <= 1'b1;
               r_busy  <= 1'b0;
            end
            default: r_state <= IDLE;
         endcase
      end
   end
   assign io_bus.cmd_ready   = r_ready;
   assign io_bus.busy        = r_busy;
   assign io_bus.vrf_rd_en   = r_rd_en;
   assign io_bus.vrf_rd_addr = r_rd_en ? r_rd_addr : '0;
   assign io_bus.out_valid   = r_out_valid;
   assign io_bus.out_vec0    = r_out_valid ? io_bus.vrf_rd_data : '0;
   assign io_bus.out_vec1    = r_out_valid ? r_scalar : '0;
   assign io_bus.out_sew     = r_out_valid ? r_sew : '0;
   assign io_bus.out_opSel   = r_out_valid & r_opsel;
   assign io_bus.out_insert  = r_out_valid & r_insert;
   assign io_bus.out_start   = r_out_start;
   assign io_bus.out_end     = r_out_end;
   assign io_bus.out_addr    = r_out_addr;
   assign io_bus.out_be      = r_out_be;
endmodule

// File: tb/tb_vslide_issue.sv
// tb_vslide_issue: scoreboard bench for vslide_issue with a VRF model and a
// command-level reference model; cycle numbers count clock edges, and a
// signal "at edge e" is observed at the negedge just before edge e.
module tb_vslide_issue;
   localparam int DW = 64, AW = 32, SW = 2, VW = 16, BE = 8;
   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;
   vslide_issue_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .SEW_WIDTH(SW), .VL_WIDTH(VW), .BE_WIDTH(BE)) bus ();
   vslide_issue #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .SEW_WIDTH(SW), .VL_WIDTH(VW), .BE_WIDTH(BE)) dut (
      .i_clk(clk),
      .i_rst_n(rst_n),
      .io_bus(bus)
   );
   typedef struct packed {
      logic [63:0] vec0;
      logic [63:0] vec1;
      logic [1:0]  sew;
      logic        opsel;
      logic        insert;
      logic        start;
      logic        last;
      logic [31:0] addr;
      logic [7:0]  be;
   } beat_t;
   typedef struct {int e; beat_t b;} exp_beat_t;
   typedef struct {int e; logic [31:0] addr;} exp_rd_t;
   exp_beat_t oq[$];
   exp_rd_t   rq[$];
   int cyc = 0, n_chk = 0, n_pass = 0, busy_lo = 1, busy_hi = 0;
   bit chk_on = 0;
   function automatic logic [63:0] vrf_word(input logic [31:0] a);
      return {a ^ 32'h5A5A_C3C3, ~a + 32'd7};
   endfunction
   task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
      n_chk++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %h expected %h", name, act, exp);
   endtask
   task automatic fail_msg(input string s);
      n_chk++;
      $display("FAIL %s", s);
   endtask
   task automatic junk();
      bus.cmd_opSel    = 1'($urandom);
      bus.cmd_insert   = 1'($urandom);
      bus.cmd_sew      = 2'($urandom);
      bus.cmd_vl       = 16'($urandom);
      bus.cmd_src_addr = $urandom;
      bus.cmd_dst_addr = $urandom;
      bus.cmd_scalar   = {$urandom, $urandom};
   endtask
   initial forever begin
      @(posedge clk);
      cyc++;
   end
   // VRF: data for a read seen in one cycle is presented during the next
   initial begin
      logic pend;
      logic [31:0] pa;
      bus.vrf_rd_data = '0;
      forever begin
         @(negedge clk);
         pend = bus.vrf_rd_en;
         pa   = bus.vrf_rd_addr;
         @(posedge clk);
         #1;
         bus.vrf_rd_data = (pend === 1'b1) ? vrf_word(pa) : {$urandom, $urandom};
      end
   end
   // monitor
   initial begin
      bit eb;
      exp_rd_t r;
      exp_beat_t o;
      beat_t act;
      forever begin
         @(negedge clk);
         if (chk_on) begin
            eb = (cyc >= busy_lo && cyc <= busy_hi);
            check("busy_ready", {bus.busy, bus.cmd_ready}, {eb, !eb});
            if (bus.vrf_rd_en) begin
               if (rq.size() == 0) fail_msg($sformatf("rd_unexpected: read addr %h at edge %0d, required none", bus.vrf_rd_addr, cyc + 1));
               else begin
                  r = rq.pop_front();
                  check("rd", {32'(cyc + 1), bus.vrf_rd_addr}, {32'(r.e), r.addr});
               end
            end else if (rq.size() != 0 && rq[0].e <= cyc + 1) begin
               r = rq.pop_front();
               fail_msg($sformatf("rd_missing: no read at edge %0d, required addr %h", cyc + 1, r.addr));
            end
            act = {bus.out_vec0, bus.out_vec1, bus.out_sew, bus.out_opSel, bus.out_insert,
                   bus.out_start, bus.out_end, bus.out_addr, bus.out_be};
            if (bus.out_valid) begin
               if (oq.size() == 0) fail_msg($sformatf("beat_unexpected: beat %h at edge %0d, required none", act, cyc + 1));
               else begin
                  o = oq.pop_front();
                  check("beat", {32'(cyc + 1), act}, {32'(o.e), o.b});
               end
            end else begin
               check("idle_zero", {8'd0, act}, '0);
               if (oq.size() != 0 && oq[0].e <= cyc + 1) begin
                  o = oq.pop_front();
                  fail_msg($sformatf("beat_missing: no beat at edge %0d, required %h", cyc + 1, o.b));
               end
            end
         end
      end
   end
   task automatic send(input logic op, input logic ins, input logic [1:0] sew, input logic [15:0] vl,
                       input logic [31:0] src, input logic [31:0] dst, input logic [63:0] sc,
                       input bit hold, output int t);
      int bytes, n, w, rem;
      exp_beat_t eo;
      exp_rd_t er;
      bus.cmd_valid    = 1'b1;
      bus.cmd_opSel    = op;
      bus.cmd_insert   = ins;
      bus.cmd_sew      = sew;
      bus.cmd_vl       = vl;
      bus.cmd_src_addr = src;
      bus.cmd_dst_addr = dst;
      bus.cmd_scalar   = sc;
      w = 0;
      do begin
         @(negedge clk);
         w++;
      end while (bus.cmd_ready !== 1'b1 && w < 300);
      if (bus.cmd_ready !== 1'b1) begin
         fail_msg($sformatf("accept_timeout: cmd_ready=%b after %0d cycles, required 1", bus.cmd_ready, w));
         bus.cmd_valid = 1'b0;
         t = -1;
         return;
      end
      t     = cyc + 1;
      bytes = int'(vl) << sew;
      n     = (bytes + BE - 1) / BE;
      rem   = bytes % BE;
      for (int k = 0; k < n; k++) begin
         er.e       = t + 1 + k;
         er.addr    = src + 32'(k);
         eo.e       = t + 2 + k;
         eo.b.vec0  = vrf_word(src + 32'(k));
         eo.b.vec1  = sc;
         eo.b.sew   = sew;
         eo.b.opsel = op;
         eo.b.insert = ins;
         eo.b.start = (k == 0);
         eo.b.last  = (k == n - 1);
         eo.b.addr  = dst + 32'(k);
         eo.b.be    = (k == n - 1 && rem != 0) ? 8'((1 << rem) - 1) : 8'hFF;
         rq.push_back(er);
         oq.push_back(eo);
      end
      if (n > 0) begin
         busy_lo = t;
         busy_hi = t + n;
      end
      @(posedge clk);
      #1;
      if (!hold) begin
         bus.cmd_valid = 1'b0;
         junk();
      end
   endtask
   // reset lands on the edge where beat 1 is presented; later beats and reads are dropped
   task automatic mid_reset();
      int r;
      @(posedge clk);
      @(posedge clk);
      #1;
      r = cyc + 1;
      rst_n = 1'b0;
      while (oq.size() != 0 && oq[$].e > r) void'(oq.pop_back());
      while (rq.size() != 0 && rq[$].e > r) void'(rq.pop_back());
      busy_hi = r - 1;
      @(posedge clk);
      #1;
      rst_n = 1'b1;
   endtask
   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end
   initial begin
      int t1, t2, w;
      logic [1:0] sew;
      logic [15:0] vl;
      logic [31:0] src, dst;
      bit hold;
      bus.cmd_valid = 1'b0;
      junk();
      repeat (3) @(posedge clk);
      #1;
      rst_n = 1'b1;
      check("reset_state", {bus.busy, bus.cmd_ready, bus.out_valid, bus.vrf_rd_en}, 4'b0100);
      chk_on = 1;
      send(1'b0, 1'b0, 2'd0, 16'd20, 32'h10, 32'h40, 64'h1234_5678_9ABC_DEF0, 1'b0, t1);
      send(1'b0, 1'b1, 2'd3, 16'd1, 32'h200, 32'h300, 64'h77, 1'b1, t1);
      send(1'b1, 1'b0, 2'd1, 16'd0, 32'h0, 32'h0, 64'h0, 1'b0, t2);
      check("ready_back_1beat", 256'(t2), 256'(t1 + 3));
      send(1'b0, 1'b0, 2'd2, 16'd0, 32'h5, 32'h6, 64'h1, 1'b1, t1);
      send(1'b1, 1'b1, 2'd3, 16'd0, 32'h7, 32'h8, 64'h2, 1'b0, t2);
      check("vl0_back_to_back", 256'(t2), 256'(t1 + 1));
      send(1'b1, 1'b0, 2'd2, 16'd3, 32'h80, 32'h90, 64'hDEAD, 1'b0, t1);
      send(1'b0, 1'b0, 2'd1, 16'd9, 32'hA0, 32'hB0, 64'hCAFE, 1'b1, t1);
      send(1'b1, 1'b1, 2'd0, 16'd5, 32'hC0, 32'hD0, 64'hBEEF, 1'b0, t2);
      check("held_accept", 256'(t2), 256'(t1 + 5));
      send(1'b0, 1'b0, 2'd3, 16'd4, 32'h400, 32'h500, 64'hF00D, 1'b0, t1);
      mid_reset();
      repeat (6) @(posedge clk);
      #1;
      for (int i = 0; i < 40; i++) begin
         sew  = 2'($urandom_range(0, 3));
         vl   = ($urandom_range(0, 4) == 0) ? 16'($urandom_range(0, 2)) : 16'($urandom_range(1, 40));
         src  = ($urandom_range(0, 3) == 0) ? 32'hFFFF_FFFE : $urandom;
         dst  = ($urandom_range(0, 3) == 0) ? 32'hFFFF_FFFC : $urandom;
         hold = (i != 39) && ($urandom_range(0, 2) == 0);
         send(1'($urandom), 1'($urandom), sew, vl, src, dst, {$urandom, $urandom}, hold, t1);
         if (!hold) begin
            repeat ($urandom_range(0, 2)) @(posedge clk);
            #1;
         end
      end
      w = 0;
      while ((oq.size() != 0 || rq.size() != 0) && w < 500) begin
         @(posedge clk);
         w++;
      end
      repeat (5) @(posedge clk);
      #1;
      check("drain_empty", {oq.size(), rq.size()}, '0);
      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end
endmodule
